// File: rtl/par2ser_pkg.sv
// par2ser_pkg: shared FSM encoding and default word width for par2ser_feed
package par2ser_pkg;
  localparam int W_DEF = 8;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/par2ser_feed.sv
// par2ser_feed: MSB-first serializer with one-entry holding buffer for zero-gap streaming
module par2ser_feed
  import par2ser_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         data_out,
  output logic         out_vld,
  output logic         out_last,
  output logic         busy
);
  localparam int CW = $clog2(W);
  state_t state, state_n;
  logic [W-1:0] sreg, sreg_n, hold, hold_n;
  logic [CW-1:0] cnt, cnt_n;
  logic full, full_n, xfer, last;
  assign in_ready = ~full;
  assign xfer = in_valid & ~full;
  assign last = (state == SHIFT) && (cnt == CW'(W - 1));
  assign data_out = (state == SHIFT) & sreg[W-1];
  assign out_vld = state == SHIFT;
  assign out_last = last;
  assign busy = (state == SHIFT) | full;
  // next state: load from input or buffer at word boundaries, otherwise shift
  always_comb begin
    state_n = state;
    sreg_n = sreg;
    cnt_n = cnt;
    hold_n = hold;
    full_n = full;
    if (state == IDLE) begin
      if (xfer) begin
        sreg_n = in_data;
        cnt_n = '0;
        state_n = SHIFT;
      end
    end else if (last) begin
      cnt_n = '0;
      if (full) begin
        sreg_n = hold;
        full_n = 1'b0;
      end else if (xfer) begin
        sreg_n = in_data;
      end else begin
        sreg_n = sreg << 1;
        state_n = IDLE;
      end
    end else begin
      sreg_n = sreg << 1;
      cnt_n = cnt + 1'b1;
      if (xfer) begin
        hold_n = in_data;
        full_n = 1'b1;
      end
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
      hold <= '0;
      full <= 1'b0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      cnt <= cnt_n;
      hold <= hold_n;
      full <= full_n;
    end
  end
endmodule

// File: tb/tb_par2ser_feed.sv
// tb_par2ser_feed: random and directed stimulus checked against a bit-queue reference model
module tb_par2ser_feed;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, data_out, out_vld, out_last, busy;
  int n_tests = 0, n_fail = 0;
  logic exp_q[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] word_acc = '0;
  always #5 clk = ~clk;
  par2ser_feed #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_vld(out_vld),
    .out_last(out_last), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
    int n;
    logic ev, el, eb;
    @(negedge clk);
    n = exp_q.size();
    ev = n > 0;
    el = ev && ((n - 1) % W == 0);
    eb = ev ? exp_q[0] : 1'b0;
    chk("out_vld", out_vld, ev);
    chk("busy", busy, ev);
    chk("in_ready", in_ready, n <= W);
    chk("data_out", data_out, eb);
    chk("out_last", out_last, el);
    if (ev) begin
      word_acc = {word_acc[W-2:0], data_out};
      void'(exp_q.pop_front());
      if (el && wq.size() > 0) begin
        chk("word", word_acc, wq[0]);
        chk("mod7", word_acc % 7, wq[0] % 7);
        void'(wq.pop_front());
      end
    end
    in_valid = v;
    in_data = d;
    rst_n = r;
    acc = r && v && (n <= W);
    if (!r) begin
      exp_q.delete();
      wq.delete();
      word_acc = '0;
    end else if (acc) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
      wq.push_back(d);
    end
  endtask
  task automatic send(input logic [W-1:0] d);
    logic a;
    int k = 0;
    do begin
      step(1'b1, d, 1'b1, a);
      k++;
    end while (!a && k < 50);
    if (!a) chk("send_timeout", 32'd0, 32'd1);
  endtask
  task automatic idle(input int n);
    logic a;
    repeat (n) step(1'b0, '0, 1'b1, a);
  endtask
  task automatic wait_left(input int left);
    int k = 0;
    while (exp_q.size() != left && k < 60) begin
      idle(1);
      k++;
    end
    if (exp_q.size() != left) chk("wait_timeout", exp_q.size(), left);
  endtask
  initial begin
    logic a;
    repeat (3) step(1'b0, '0, 1'b0, a);
    idle(2);
    send(8'hB5);
    idle(12);
    send(8'hFF);
    send(8'h00);
    idle(20);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    idle(30);
    send(8'h0E);
    wait_left(1);
    step(1'b1, 8'h07, 1'b1, a);
    chk("bypass_acc", a, 1'b1);
    idle(12);
    send(8'hA5);
    wait_left(4);
    step(1'b0, '0, 1'b0, a);
    idle(2);
    send(8'h3C);
    idle(12);
    for (int i = 0; i < 600; i++)
      step(1'(($urandom % 3) != 0), W'($urandom), 1'(($urandom % 80) != 0), a);
    idle(30);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/par2ser_feed.md
PAR2SER_FEED -- requirements
Module: par2ser_feed

Interface
REQ-001 SHALL have parameter W, default 8, meaning word width in bits (W >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_data  input  W  parallel word to serialize.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port data_out  output  1  serial bit, MSB first; drives the mod-7 checker's data_in.
REQ-008 SHALL have port out_vld  output  1  data_out carries a word bit this cycle.
REQ-009 SHALL have port out_last  output  1  data_out is bit 0 (LSB) of the current word.
REQ-010 SHALL have port busy  output  1  shifter active or holding buffer occupied.

Function
REQ-011 SHALL register a transfer on any rising edge with in_valid=1 and in_ready=1; no transfer otherwise.
REQ-012 SHALL hold a W-bit shift register, a bit counter of clog2(W) bits, and a one-entry holding buffer with full flag.
REQ-013 SHALL implement FSM states IDLE and SHIFT; reset enters IDLE.
REQ-014 SHALL drive in_ready = ~buf_full, combinationally from registered state only (no dependence on in_valid).
REQ-015 In IDLE, a transfer SHALL load in_data into the shift register, clear the counter and enter SHIFT; the word's MSB appears on data_out in the next cycle (latency 1).
REQ-016 In SHIFT, data_out SHALL equal shift register bit W-1, out_vld=1; each cycle shift left by one and increment counter.
REQ-017 out_last SHALL be 1 exactly when counter = W-1 in SHIFT.
REQ-018 When out_last=1 and buf_full=1, next edge SHALL move buffer into shift register, clear buf_full, stay in SHIFT; zero-gap stream.
REQ-019 When out_last=1, buf_full=0 and a transfer occurs that edge, in_data SHALL load directly into the shift register (bypass), stay in SHIFT.
REQ-020 When out_last=1, buf_full=0 and no transfer, SHALL enter IDLE next edge.
REQ-021 A transfer in SHIFT while not on the last bit SHALL write the holding buffer and set buf_full.
REQ-022 In IDLE, data_out, out_vld and out_last SHALL be 0; zero bits preserve the downstream residue-zero property.
REQ-023 busy SHALL equal (state==SHIFT) | buf_full.
REQ-024 Each accepted word SHALL be emitted exactly once, in acceptance order, as W consecutive valid bits; no word dropped or duplicated.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, counter 0, shift register 0, buffer 0, buf_full 0, regardless of state.
REQ-026 During and the cycle after reset: data_out=0, out_vld=0, out_last=0, busy=0, in_ready=1.
REQ-027 Reset mid-word SHALL discard the partial word and any buffered word; no transfer is registered on a reset edge.

Structure
REQ-028 SHALL place state encoding (IDLE, SHIFT) and default W in a shared package (par2ser_pkg).
REQ-029 SHALL be a single module with no sub-modules; counter width derived via $clog2(W).

Verification
REQ-030 Single word: reset, send 0xB5 once -> data_out 1,0,1,1,0,1,0,1 on 8 consecutive cycles after acceptance, out_last only on 8th, then IDLE, out_vld=0.
REQ-031 Back-to-back: 0xFF then 0x00 with in_valid held -> 16 contiguous valid bits (eight 1s, eight 0s), no gap, second word accepted into buffer, in_ready low until buffer drains.
REQ-032 Backpressure: in_valid held with three words 0x01,0x02,0x03 -> in_ready=0 while buf_full; all three emitted in order, total 24 valid bits.
REQ-033 Bypass: present 0x07 exactly on out_last cycle of 0x0E with buffer empty -> 0x07 MSB follows 0x0E LSB with no gap.
REQ-034 Reset mid-word: assert rst_n=0 at bit 4 of 0xA5 -> next cycle out_vld=0, busy=0, in_ready=1; next word 0x3C emitted intact.
REQ-035 End-to-end: feed random words into par2ser_feed -> mol7 chain; checker vld SHALL match (accumulated MSB-first value mod 7 == 0) every cycle.
